adc_sample_sequencer: RTL and testbench

Periodic ADC sample scheduler and block averager placed between the ADC interface and the display-mode mux. It issues timed conversion requests over a req/valid handshake and accumulates 2^AVG_LOG2 samples into a truncated mean. It drives the raw and averaged values consumed by the voltage/distance conversion path, and freezes both outputs while the debounced hold button is inactive.

---
 rtl/adc_sample_sequencer_if.sv | 39 +++
 rtl/adc_sample_sequencer.sv | 114 +++++++++++
 tb/tb_adc_sample_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_sequencer_if.sv
// ADC request/response handshake plus the sequencer's result and status signals.
// The master side is the sequencer; the slave side is the ADC front end and display consumers.
interface adc_sample_sequencer_if #(
    parameter int unsigned DATA_W = 12
);
    logic              enable;
    logic              adc_req;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] sample_out;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              overrun;
    logic              timeout_err;

    modport master (
        input  enable,
        input  adc_valid,
        input  adc_data,
        output adc_req,
        output sample_out,
        output avg_out,
        output avg_valid,
        output overrun,
        output timeout_err
    );

    modport slave (
        output enable,
        output adc_valid,
        output adc_data,
        input  adc_req,
        input  sample_out,
        input  avg_out,
        input  avg_valid,
        input  overrun,
        input  timeout_err
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC conversion scheduler with a 2^AVG_LOG2-sample truncating block averager.
// Outputs freeze while enable is low; sampling and accumulation keep running.
module adc_sample_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned AVG_LOG2      = 8,
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned TIMEOUT       = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_sample_sequencer_if.master bus
);
    localparam int unsigned TickW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned WaitW = $clog2(TIMEOUT);
    localparam int unsigned AccW  = DATA_W + AVG_LOG2;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e              state_q, state_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;
    logic                tick;

    // Free-running; independent of enable and of the FSM.
    assign tick       = (tick_cnt_q == TickW'(SAMPLE_PERIOD - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        sample_d      = sample_q;
        avg_d         = avg_q;
        avg_valid_d   = 1'b0;
        overrun_d     = overrun_q | (tick && (state_q != StIdle));
        timeout_err_d = timeout_err_q;

        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d    = StReq;
                    wait_cnt_d = '0;
                end
            end
            StReq: begin
                // A response arriving in the timeout cycle still counts.
                if (bus.adc_valid) begin
                    acc_d = acc_q + AccW'(bus.adc_data);
                    cnt_d = cnt_q + AVG_LOG2'(1);
                    if (bus.enable) begin
                        sample_d = bus.adc_data;
                    end
                    state_d = (cnt_q == '1) ? StDone : StIdle;
                end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StDone: begin
                if (bus.enable) begin
                    avg_d       = acc_q[AccW-1:AVG_LOG2];
                    avg_valid_d = 1'b1;
                end
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            sample_q      <= '0;
            avg_q         <= '0;
            avg_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            sample_q      <= sample_d;
            avg_q         <= avg_d;
            avg_valid_q   <= avg_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.adc_req     = (state_q == StReq);
    assign bus.sample_out  = sample_q;
    assign bus.avg_out     = avg_q;
    assign bus.avg_valid   = avg_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: a main instance (TIMEOUT=8) and a second
// instance (TIMEOUT=16) whose ADC stays silent so ticks land during REQ.
module tb_adc_sample_sequencer;
    localparam int unsigned DW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adc_sample_sequencer_if #(.DATA_W(DW)) bus ();
    adc_sample_sequencer_if #(.DATA_W(DW)) bus_ov ();

    adc_sample_sequencer #(
        .SAMPLE_PERIOD(10), .AVG_LOG2(2), .DATA_W(DW), .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    adc_sample_sequencer #(
        .SAMPLE_PERIOD(10), .AVG_LOG2(2), .DATA_W(DW), .TIMEOUT(16)
    ) dut_ov (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_ov)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int avg_pulses = 0;

    always @(posedge clk) begin
        if (bus.avg_valid) avg_pulses <= avg_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.adc_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ADC model: answers 2 cycles after adc_req rises; returns just after acceptance.
    task automatic feed(input logic [DW-1:0] val);
        bit seen;
        wait_req(seen);
        check_eq("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        @(negedge clk);
        bus.adc_valid = 1'b1;
        bus.adc_data  = val;
        @(negedge clk);
        bus.adc_valid = 1'b0;
    endtask

    task automatic feed_block(input logic [DW-1:0] vals [4], input logic [DW-1:0] exp_avg,
                              input string tag);
        int p;
        p = avg_pulses;
        for (int i = 0; i < 4; i++) begin
            feed(vals[i]);
            check_eq({tag, "_sample"}, 32'(bus.sample_out), 32'(vals[i]));
        end
        check_eq({tag, "_vld_early"}, 32'(bus.avg_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_vld"}, 32'(bus.avg_valid), 32'd1);
        check_eq({tag, "_avg"}, 32'(bus.avg_out), 32'(exp_avg));
        @(negedge clk);
        check_eq({tag, "_vld_late"}, 32'(bus.avg_valid), 32'd0);
        check_eq({tag, "_pulses"}, 32'(avg_pulses - p), 32'd1);
    endtask

    initial begin
        bit seen;
        int hi;
        int p;

        bus.enable       = 1'b1;
        bus.adc_valid    = 1'b0;
        bus.adc_data     = '0;
        bus_ov.enable    = 1'b1;
        bus_ov.adc_valid = 1'b0;
        bus_ov.adc_data  = '0;
        reset            = 1'b1;

        // Reset with adc_valid toggling.
        for (int i = 0; i < 3; i++) begin
            bus.adc_valid = ~bus.adc_valid;
            bus.adc_data  = 12'hABC;
            @(negedge clk);
        end
        check_eq("rst_req", 32'(bus.adc_req), 32'd0);
        check_eq("rst_sample", 32'(bus.sample_out), 32'd0);
        check_eq("rst_avg", 32'(bus.avg_out), 32'd0);
        check_eq("rst_vld", 32'(bus.avg_valid), 32'd0);
        check_eq("rst_ovr", 32'(bus.overrun), 32'd0);
        check_eq("rst_to", 32'(bus.timeout_err), 32'd0);
        check_eq("rst_ov_ovr", 32'(bus_ov.overrun), 32'd0);
        reset         = 1'b0;
        bus.adc_valid = 1'b0;

        repeat (9) @(negedge clk);
        check_eq("req_before_tick", 32'(bus.adc_req), 32'd0);
        @(negedge clk);
        check_eq("first_req", 32'(bus.adc_req), 32'd1);

        feed_block('{12'd1, 12'd1, 12'd1, 12'd2}, 12'd1, "trunc");
        feed_block('{12'd100, 12'd200, 12'd300, 12'd400}, 12'd250, "avg");

        // Frozen block: accumulated but discarded.
        bus.enable = 1'b0;
        p = avg_pulses;
        for (int i = 0; i < 4; i++) feed(12'd4095);
        repeat (2) @(negedge clk);
        check_eq("frz_sample", 32'(bus.sample_out), 32'd400);
        check_eq("frz_avg", 32'(bus.avg_out), 32'd250);
        check_eq("frz_pulses", 32'(avg_pulses - p), 32'd0);
        bus.enable = 1'b1;
        feed_block('{12'd8, 12'd8, 12'd8, 12'd8}, 12'd8, "unfrz");

        // Silent ADC: req held exactly TIMEOUT cycles.
        wait_req(seen);
        check_eq("to_req_seen", 32'(seen), 32'd1);
        hi = 0;
        while (bus.adc_req && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        check_eq("to_req_len", 32'(hi), 32'd8);
        check_eq("to_err", 32'(bus.timeout_err), 32'd1);
        check_eq("to_sample", 32'(bus.sample_out), 32'd8);
        feed_block('{12'd40, 12'd40, 12'd40, 12'd40}, 12'd40, "after_to");
        check_eq("to_sticky", 32'(bus.timeout_err), 32'd1);

        check_eq("main_no_ovr", 32'(bus.overrun), 32'd0);
        check_eq("ov_ovr", 32'(bus_ov.overrun), 32'd1);
        check_eq("ov_to", 32'(bus_ov.timeout_err), 32'd1);

        // One normal handshake on the overrun instance; flag must stay set.
        hi = 0;
        while (!bus_ov.adc_req && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check_eq("ov_req_seen", 32'(bus_ov.adc_req), 32'd1);
        bus_ov.adc_valid = 1'b1;
        bus_ov.adc_data  = 12'd77;
        @(negedge clk);
        bus_ov.adc_valid = 1'b0;
        check_eq("ov_sample", 32'(bus_ov.sample_out), 32'd77);
        check_eq("ov_sticky", 32'(bus_ov.overrun), 32'd1);

        // Partial block then reset.
        feed(12'd500);
        feed(12'd500);
        check_eq("mid_sample", 32'(bus.sample_out), 32'd500);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_req", 32'(bus.adc_req), 32'd0);
        check_eq("mid_rst_avg", 32'(bus.avg_out), 32'd0);
        check_eq("mid_rst_sample", 32'(bus.sample_out), 32'd0);
        check_eq("mid_rst_to", 32'(bus.timeout_err), 32'd0);
        check_eq("mid_rst_ov_ovr", 32'(bus_ov.overrun), 32'd0);
        feed_block('{12'd12, 12'd12, 12'd12, 12'd12}, 12'd12, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
